// File: rtl/fixed_point_pwl_act.sv
// rtl/fixed_point_pwl_act.sv - pipelined piecewise-linear activation with runtime segment table
module fixed_point_pwl_act #(
    parameter int WIDTH     = 16,
    parameter int FRAC_BITS = 13,
    parameter int NUM_SEGS  = 8,
    localparam int SEG_W    = $clog2(NUM_SEGS)
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    cfg_we_i,
    input  logic [1:0]              cfg_sel_i,
    input  logic [SEG_W-1:0]        cfg_addr_i,
    input  logic signed [WIDTH-1:0] cfg_data_i,
    input  logic [1:0]              mode_i,
    input  logic                    clr_ovf_i,
    input  logic signed [WIDTH-1:0] value_i,
    input  logic                    valid_i,
    output logic                    ready_o,
    output logic signed [WIDTH-1:0] value_o,
    output logic                    valid_o,
    input  logic                    ready_i,
    output logic                    overflow_o
);

    localparam int PW = 2 * WIDTH;
    localparam logic signed [WIDTH-1:0] MAX_V = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH-1:0] MIN_V = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic signed [PW-1:0]    ONE_P = {{(PW-FRAC_BITS-1){1'b0}}, 1'b1, {FRAC_BITS{1'b0}}};

    function automatic logic signed [PW-1:0] sext(input logic signed [WIDTH-1:0] v);
        sext = {{WIDTH{v[WIDTH-1]}}, v};
    endfunction

    // Returns {saturated, clamped value}; a value fits when its top WIDTH+1 bits agree.
    function automatic logic [WIDTH:0] sat_w(input logic signed [PW-1:0] v);
        logic fits;
        fits = (&v[PW-1:WIDTH-1]) | (~|v[PW-1:WIDTH-1]);
        if (fits)
            sat_w = {1'b0, v[WIDTH-1:0]};
        else if (v[PW-1])
            sat_w = {1'b1, MIN_V};
        else
            sat_w = {1'b1, MAX_V};
    endfunction

    logic signed [WIDTH-1:0] bp_q [1:NUM_SEGS-1];
    logic signed [WIDTH-1:0] m_q  [NUM_SEGS];
    logic signed [WIDTH-1:0] q_q  [NUM_SEGS];

    logic                    en;
    logic                    v0_q, v1_q, v2_q, out_valid_q;
    logic                    sign0_q, sign1_q, sign2_q;
    logic [1:0]              mode0_q, mode1_q, mode2_q;
    logic signed [WIDTH-1:0] key0_q, key1_q, m1_q, q1_q, p2_q, q2_q, out_value_q;
    logic                    ovf_q, ovf_set;

    assign en         = !out_valid_q || ready_i;
    assign ready_o    = en;
    assign value_o    = out_value_q;
    assign valid_o    = out_valid_q;
    assign overflow_o = ovf_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NUM_SEGS; i++) begin
                m_q[i] <= '0;
                q_q[i] <= '0;
            end
            for (int i = 1; i < NUM_SEGS; i++) begin
                bp_q[i] <= MAX_V;
            end
        end else if (cfg_we_i) begin
            case (cfg_sel_i)
                2'd0: if (cfg_addr_i != '0) bp_q[cfg_addr_i] <= cfg_data_i;
                2'd1: m_q[cfg_addr_i] <= cfg_data_i;
                2'd2: q_q[cfg_addr_i] <= cfg_data_i;
                default: ;
            endcase
        end
    end

    // S0: symmetric modes fold the input onto its magnitude.
    logic                    sym_in, abs_sat;
    logic signed [WIDTH-1:0] key_d;
    always_comb begin
        sym_in  = (mode_i == 2'd0) || (mode_i == 2'd1);
        abs_sat = sym_in && (value_i == MIN_V);
        key_d   = value_i;
        if (sym_in && value_i[WIDTH-1]) key_d = abs_sat ? MAX_V : -value_i;
    end

    // S1: the highest matching breakpoint wins, even if the table is not ascending.
    logic [SEG_W-1:0] seg;
    always_comb begin
        seg = '0;
        for (int i = 1; i < NUM_SEGS; i++) begin
            if (key0_q >= bp_q[i]) seg = SEG_W'(i);
        end
    end

    logic signed [PW-1:0] prod, prod_sh;
    logic [WIDTH:0]       p_sat;
    always_comb begin
        prod    = sext(key1_q) * sext(m1_q);
        prod_sh = prod >>> FRAC_BITS;
        p_sat   = sat_w(prod_sh);
    end

    logic signed [PW-1:0]    sum, t_ext;
    logic [WIDTH:0]          t_r, neg_r, sig_r;
    logic signed [WIDTH-1:0] out_d;
    logic                    ovf3;
    always_comb begin
        sum   = sext(p2_q) + sext(q2_q);
        t_r   = sat_w(sum);
        t_ext = sext(t_r[WIDTH-1:0]);
        neg_r = sat_w(-t_ext);
        sig_r = sat_w(ONE_P - t_ext);
        out_d = t_r[WIDTH-1:0];
        ovf3  = t_r[WIDTH];
        if (sign2_q && mode2_q == 2'd0) begin
            out_d = neg_r[WIDTH-1:0];
            ovf3  = ovf3 | neg_r[WIDTH];
        end else if (sign2_q && mode2_q == 2'd1) begin
            out_d = sig_r[WIDTH-1:0];
            ovf3  = ovf3 | sig_r[WIDTH];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            v0_q        <= 1'b0;
            v1_q        <= 1'b0;
            v2_q        <= 1'b0;
            out_valid_q <= 1'b0;
            out_value_q <= '0;
            sign0_q     <= 1'b0;
            sign1_q     <= 1'b0;
            sign2_q     <= 1'b0;
            mode0_q     <= '0;
            mode1_q     <= '0;
            mode2_q     <= '0;
            key0_q      <= '0;
            key1_q      <= '0;
            m1_q        <= '0;
            q1_q        <= '0;
            p2_q        <= '0;
            q2_q        <= '0;
        end else if (en) begin
            v0_q        <= valid_i;
            sign0_q     <= value_i[WIDTH-1];
            mode0_q     <= mode_i;
            key0_q      <= key_d;
            v1_q        <= v0_q;
            sign1_q     <= sign0_q;
            mode1_q     <= mode0_q;
            key1_q      <= key0_q;
            m1_q        <= m_q[seg];
            q1_q        <= q_q[seg];
            v2_q        <= v1_q;
            sign2_q     <= sign1_q;
            mode2_q     <= mode1_q;
            p2_q        <= p_sat[WIDTH-1:0];
            q2_q        <= q1_q;
            out_valid_q <= v2_q;
            out_value_q <= out_d;
        end
    end

    assign ovf_set = en && ((valid_i && abs_sat) || (v1_q && p_sat[WIDTH]) || (v2_q && ovf3));

    always_ff @(posedge clk_i) begin
        if (rst_i)
            ovf_q <= 1'b0;
        else if (ovf_set)
            ovf_q <= 1'b1;
        else if (clr_ovf_i)
            ovf_q <= 1'b0;
    end

endmodule
